// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer: shift-add multiplier and restoring divider on operand
// magnitudes with sign fix-up into HI/LO. Define MULDIV_EARLY_OUT_EN for MULT early termination.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;
  localparam logic [3:0] OP_MULT = 4'b1000, OP_DIV = 4'b1001;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic               is_div, neg_a, neg_b;
  // opnd: |a| (multiplicand) for MULT, |b| (divisor) for DIV; mplr shifts |b| for MULT
  logic [WIDTH-1:0]   opnd, mplr;
  // MULT: running product; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               op_ok;
  logic [WIDTH:0]     add_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               early;

  always_comb begin
    mag_a     = a[WIDTH-1] ? -a : a;
    mag_b     = b[WIDTH-1] ? -b : b;
    op_ok     = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, opnd} : '0);
    mul_next  = {add_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    // A borrow out of the trial subtract means the shifted remainder is kept (restore)
    if (div_trial[WIDTH])
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix  = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix   = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

`ifdef MULDIV_EARLY_OUT_EN
  // No multiplier bits left after this iteration: the rest are pure shifts
  assign early = !is_div && (mplr[WIDTH-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      opnd        <= '0;
      mplr        <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && op_ok) begin
            is_div      <= (alu_op == OP_DIV);
            neg_a       <= a[WIDTH-1];
            neg_b       <= b[WIDTH-1];
            count       <= '0;
            div_by_zero <= 1'b0;
            if (alu_op == OP_DIV) begin
              opnd <= mag_b;
              mplr <= '0;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              mplr <= mag_b;
              acc  <= '0;
            end
            if ((alu_op == OP_DIV) && (b == '0)) begin
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          count <= count + 1'b1;
          mplr  <= mplr >> 1;
          if (is_div)
            acc <= div_next;
`ifdef MULDIV_EARLY_OUT_EN
          else if (early)
            acc <= mul_next >> (LAST - count);
`endif
          else
            acc <= mul_next;
          if ((count == LAST) || early) begin
            count <= '0;
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model with per-cycle output compare,
// plus directed vectors with literal expected values.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [3:0] MULT = 4'b1000, DIV = 4'b1001;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   alu_op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_by_zero;
  int           checks = 0, errors = 0;
  bit           chk_en = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result from plain signed arithmetic
  function automatic logic [2*W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] av, bv);
    longint sa, sb, p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (op == MULT) begin
      p = sa * sb;
      return p[2*W-1:0];
    end
    return {W'(sa % sb), W'(sa / sb)};
  endfunction

  // Edges from acceptance until the result is written
  function automatic int calc_cycles(input logic [3:0] op, input logic [W-1:0] bv);
`ifdef MULDIV_EARLY_OUT_EN
    longint mag;
    int k;
    if (op == MULT) begin
      mag = longint'($signed(bv));
      if (mag < 0) mag = -mag;
      k = -1;
      for (int i = 0; i < W; i++) if (mag[i]) k = i;
      return (k < 0) ? 2 : k + 2;
    end
`endif
    return (op == DIV || op == MULT) ? W + 1 : W + 1;
  endfunction

  logic [W-1:0]   m_hi, m_lo;
  logic [2*W-1:0] p_res;
  bit             m_done, m_dbz;
  int             m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_done <= 0; m_dbz <= 0; m_left <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_res[2*W-1:W]; m_lo <= p_res[W-1:0]; m_done <= 1;
      end
    end else if (start && (alu_op == MULT || alu_op == DIV)) begin
      m_dbz <= 0;
      if (alu_op == DIV && b == '0) begin
        m_dbz <= 1; m_done <= 1;
      end else begin
        p_res  <= model_res(alu_op, a, b);
        m_left <= calc_cycles(alu_op, b);
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
    chk("cyc_busy", busy, m_left > 0);
    chk("cyc_done", done, m_done);
    chk("cyc_dbz", div_by_zero, m_dbz);
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, bv);
    @(negedge clk); start = 1; alu_op = op; a = av; b = bv;
    @(negedge clk); start = 0; a = 32'hDEADBEEF; b = 32'h0BADF00D;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (!done && lat < 200) begin
      if (busy) nbusy++;
      @(negedge clk); lat++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [W-1:0] av, bv,
                     input logic [W-1:0] eh, el);
    int lat, nb;
    issue(op, av, bv);
    wait_done(lat, nb);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_lat"}, lat, calc_cycles(op, bv) + 1);
  endtask

  initial begin
    int lat, nb, ndone;
    reset = 1; start = 0; alu_op = 4'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_dbz", div_by_zero, 0);
    reset = 0;

    issue(MULT, 32'd6, 32'd7);
    wait_done(lat, nb);
    chk("m67_hi", hi, 0); chk("m67_lo", lo, 42);
`ifdef MULDIV_EARLY_OUT_EN
    chk("m67_lat", lat, 5); chk("m67_busy", nb, 4);
`else
    chk("m67_lat", lat, 34); chk("m67_busy", nb, 33);
`endif

    run("m_neg3x5", MULT, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run("m_minmin", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run("d7_n2", DIV, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD);
    run("dn7_2", DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("d_min_n1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run("d23_6", DIV, 32'd23, 32'd6, 32'd5, 32'd3);

    issue(DIV, 32'd9, 32'd0);
    chk("dz_done", done, 1);
    chk("dz_flag", div_by_zero, 1);
    chk("dz_hi", hi, 5); chk("dz_lo", lo, 3);
    issue(MULT, 32'd2, 32'd3);
    chk("dz_clear", div_by_zero, 0);
    wait_done(lat, nb);
    chk("m23_lo", lo, 6);

    // start during CALC must not disturb the running op
    issue(MULT, 32'd6, 32'd7);
    repeat (2) @(negedge clk);
    start = 1; alu_op = DIV; a = 32'd100; b = 32'd3;
    @(negedge clk); start = 0;
    wait_done(lat, nb);
    chk("busy_ign_lo", lo, 42);
    @(negedge clk); start = 1; alu_op = 4'b0010; a = 32'd1; b = 32'd1;
    @(negedge clk); start = 0;
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done || busy) ndone++; end
    chk("badop_ign", ndone, 0);
    chk("badop_lo", lo, 42);

    // reset mid-operation
    issue(MULT, 32'd5, 32'h40000000);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_hi", hi, 0); chk("mid_rst_lo", lo, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    reset = 0;
    run("post_rst", MULT, 32'd2, 32'd3, 32'd0, 32'd6);

`ifdef MULDIV_EARLY_OUT_EN
    issue(MULT, 32'd6, 32'd1);
    wait_done(lat, nb);
    chk("eo_lat", lat, 3); chk("eo_lo", lo, 6);
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
